// File: rtl/read_iq.sv
// Byte-stream to I/Q sample converter: gathers 4-byte little-endian
// I/Q records and emits quantized sample pairs to two output FIFOs.
module read_iq #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BYTE_SIZE-1:0] in_dout,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic [DATA_SIZE-1:0] i_out_din,
  input  logic                 i_out_full,
  output logic                 i_out_wr_en,
  output logic [DATA_SIZE-1:0] q_out_din,
  input  logic                 q_out_full,
  output logic                 q_out_wr_en
);

  localparam int SAMP = 2 * BYTE_SIZE;

  typedef enum logic {
    S_READ,
    S_WRITE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_cnt;
  logic [BYTE_SIZE-1:0]  r_b0;
  logic [BYTE_SIZE-1:0]  r_b1;
  logic [BYTE_SIZE-1:0]  r_b2;
  logic [DATA_SIZE-1:0]  r_i;
  logic [DATA_SIZE-1:0]  r_q;
  logic                  w_pop;
  logic                  w_wr;

  function automatic logic [DATA_SIZE-1:0] quant(
    input logic [SAMP-1:0] v
  );
    logic [DATA_SIZE-1:0] ext;
    ext = {{(DATA_SIZE-SAMP){v[SAMP-1]}}, v};
    return ext << BITS;
  endfunction

  // reset gates the pop so nothing leaves the FIFO while held in reset
  assign w_pop = (r_state == S_READ) & ~in_empty & reset;
  assign w_wr  = (r_state == S_WRITE) & ~i_out_full & ~q_out_full;

  assign in_rd_en    = w_pop;
  assign i_out_wr_en = w_wr;
  assign q_out_wr_en = w_wr;
  assign i_out_din   = r_i;
  assign q_out_din   = r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_READ;
      r_cnt   <= 2'd0;
      r_b0    <= '0;
      r_b1    <= '0;
      r_b2    <= '0;
      r_i     <= '0;
      r_q     <= '0;
    end else begin
      unique case (r_state)
        S_READ: begin
          if (w_pop) begin
            r_cnt <= r_cnt + 2'd1;
            unique case (r_cnt)
              2'd0: r_b0 <= in_dout;
              2'd1: r_b1 <= in_dout;
              2'd2: r_b2 <= in_dout;
              2'd3: begin
                // Q_hi goes straight into the quantizer
                r_i     <= quant({r_b1, r_b0});
                r_q     <= quant({in_dout, r_b2});
                r_state <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (w_wr) r_state <= S_READ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Randomized and directed bench for read_iq against a
// record-level reference model.
module tb_read_iq;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] i_out_din;
  logic        i_out_full;
  logic        i_out_wr_en;
  logic [31:0] q_out_din;
  logic        q_out_full;
  logic        q_out_wr_en;

  read_iq dut (
    .clock       (clock),
    .reset       (reset),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .i_out_din   (i_out_din),
    .i_out_full  (i_out_full),
    .i_out_wr_en (i_out_wr_en),
    .q_out_din   (q_out_din),
    .q_out_full  (q_out_full),
    .q_out_wr_en (q_out_wr_en)
  );

  always #5 clock = ~clock;

  int          n_chk;
  int          n_fail;
  logic [7:0]  src[$];
  logic [31:0] eiq[$];
  logic [31:0] eqq[$];
  logic [7:0]  rec[4];
  int          bc;
  bit          pend;
  int          nwr;
  logic [31:0] last_i;
  logic [31:0] last_q;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qz(logic [7:0] lo, logic [7:0] hi);
    int v;
    v = int'($signed({hi, lo}));
    return 32'(v * 1024);
  endfunction

  task automatic push_rec(logic [15:0] i, logic [15:0] q);
    src.push_back(i[7:0]);
    src.push_back(i[15:8]);
    src.push_back(q[7:0]);
    src.push_back(q[15:8]);
  endtask

  // One cycle: drive at negedge, check, advance model, wait next negedge
  task automatic cyc(bit e, bit fi, bit fq);
    bit emp;
    bit exp_rd;
    bit exp_wr;
    emp = e || (src.size() == 0);
    in_empty   = emp;
    in_dout    = emp ? 8'($urandom) : src[0];
    i_out_full = fi;
    q_out_full = fq;
    #1;
    exp_rd = !emp && !pend;
    exp_wr = pend && !fi && !fq;
    chk("rd_en", 64'(in_rd_en), 64'(exp_rd));
    chk("i_wr_en", 64'(i_out_wr_en), 64'(exp_wr));
    chk("q_wr_en", 64'(q_out_wr_en), 64'(exp_wr));
    if (pend) begin
      chk("i_din", 64'(i_out_din), 64'(eiq[0]));
      chk("q_din", 64'(q_out_din), 64'(eqq[0]));
    end
    if (exp_wr) begin
      last_i = eiq.pop_front();
      last_q = eqq.pop_front();
      pend = 0;
      nwr++;
    end
    if (exp_rd) begin
      rec[bc] = src.pop_front();
      bc++;
      if (bc == 4) begin
        eiq.push_back(qz(rec[0], rec[1]));
        eqq.push_back(qz(rec[2], rec[3]));
        bc = 0;
        pend = 1;
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((src.size() != 0 || pend) && n < 200) begin
      cyc(0, 0, 0);
      n++;
    end
    chk("drain_done", 64'(src.size()) + 64'(pend), 64'd0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rd_en", 64'(in_rd_en), 64'd0);
    chk("rst_i_wr", 64'(i_out_wr_en), 64'd0);
    chk("rst_q_wr", 64'(q_out_wr_en), 64'd0);
    chk("rst_i_din", 64'(i_out_din), 64'd0);
    chk("rst_q_din", 64'(q_out_din), 64'd0);
  endtask

  initial begin
    int w0;
    int cycles;
    n_chk = 0;
    n_fail = 0;
    bc = 0;
    pend = 0;
    nwr = 0;
    reset = 1'b0;
    in_empty = 1'b0;
    in_dout = 8'h5A;
    i_out_full = 1'b0;
    q_out_full = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_reset_outs();
    @(negedge clock);
    reset = 1'b1;

    // Basic records
    push_rec(16'h0001, 16'hFFFF);
    drain();
    chk("r030_i", 64'(last_i), 64'h0000_0400);
    chk("r030_q", 64'(last_q), 64'hFFFF_FC00);
    push_rec(16'h7FFF, 16'h8000);
    drain();
    chk("r031_i", 64'(last_i), 64'h01FF_FC00);
    chk("r031_q", 64'(last_q), 64'hFE00_0000);

    // Empty toggling every cycle across a record
    w0 = nwr;
    push_rec(16'h1234, 16'hABCD);
    for (int k = 0; k < 10; k++) cyc(k % 2 == 0, 0, 0);
    drain();
    chk("toggle_writes", 64'(nwr - w0), 64'd1);
    chk("toggle_i", 64'(last_i), 64'(qz(8'h34, 8'h12)));

    // Q FIFO full held for 10 cycles at S_WRITE entry
    w0 = nwr;
    push_rec(16'h0042, 16'hFF00);
    push_rec(16'h0007, 16'h0008);
    while (!pend) cyc(0, 0, 1);
    for (int k = 0; k < 10; k++) cyc(0, 0, 1);
    chk("qfull_no_write", 64'(nwr - w0), 64'd0);
    chk("qfull_no_pop", 64'(src.size()), 64'd4);
    cyc(0, 0, 0);
    chk("qfull_write_after", 64'(nwr - w0), 64'd1);
    drain();

    // Reset mid-record discards partial bytes
    w0 = nwr;
    src.push_back(8'h01);
    src.push_back(8'h00);
    src.push_back(8'h02);
    src.push_back(8'h00);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset = 1'b0;
    src.delete();
    eiq.delete();
    eqq.delete();
    bc = 0;
    pend = 0;
    in_empty = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clock);
    reset = 1'b1;
    push_rec(16'h0003, 16'h0004);
    drain();
    chk("rst_writes", 64'(nwr - w0), 64'd1);
    chk("rst_i", 64'(last_i), 64'h0000_0C00);
    chk("rst_q", 64'(last_q), 64'h0000_1000);

    // Reset while a pair is pending
    w0 = nwr;
    push_rec(16'h1111, 16'h2222);
    while (!pend) cyc(0, 1, 0);
    reset = 1'b0;
    eiq.delete();
    eqq.delete();
    pend = 0;
    #1;
    chk_reset_outs();
    @(negedge clock);
    reset = 1'b1;
    cyc(1, 0, 0);
    chk("rst_pend_drop", 64'(nwr - w0), 64'd0);

    // Random records with random empty/full
    w0 = nwr;
    for (int r = 0; r < 1000; r++)
      push_rec(16'($urandom), 16'($urandom));
    cycles = 0;
    while ((src.size() != 0 || pend) && cycles < 40000) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 2);
      cycles++;
    end
    chk("rand_writes", 64'(nwr - w0), 64'd1000);
    chk("rand_left", 64'(eiq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/read_iq.md
READ_IQ -- requirements
Module: read_iq

Interface
REQ-001 Parameter DATA_SIZE, default 32: width of quantized output samples.
REQ-002 Parameter BITS, default 10: fixed-point fraction bits applied by quantization.
REQ-003 Parameter BYTE_SIZE, default 8: width of input stream bytes.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_dout  input  BYTE_SIZE  head byte of first-word-fall-through input FIFO.
REQ-007 in_empty  input  1  input FIFO empty.
REQ-008 in_rd_en  output  1  pops input FIFO head this cycle.
REQ-009 i_out_din  output  DATA_SIZE  quantized in-phase sample (feeds fir_cmplx xreal path).
REQ-010 i_out_full  input  1  I output FIFO full.
REQ-011 i_out_wr_en  output  1  push to I output FIFO.
REQ-012 q_out_din  output  DATA_SIZE  quantized quadrature sample (feeds ximag path).
REQ-013 q_out_full  input  1  Q output FIFO full.
REQ-014 q_out_wr_en  output  1  push to Q output FIFO.

Function
REQ-015 Input stream SHALL be consumed as 4-byte records: I_lo, I_hi, Q_lo, Q_hi (little-endian signed 16-bit I then Q).
REQ-016 FSM SHALL have two states: S_READ (collect bytes, 2-bit byte counter 0..3) and S_WRITE (emit pair).
REQ-017 In S_READ, in_rd_en SHALL equal NOT in_empty, combinationally; in_dout SHALL be captured into the byte slot indexed by the counter in the same cycle in_rd_en is high.
REQ-018 Counter SHALL increment only on a pop; no pop (in_empty=1) SHALL hold counter and captured bytes unchanged.
REQ-019 Pop with counter=3 SHALL wrap counter to 0 and transition to S_WRITE next cycle.
REQ-020 in_rd_en SHALL be 0 in S_WRITE; no bytes consumed while a pair is pending.
REQ-021 Quantization: each 16-bit value SHALL be sign-extended to DATA_SIZE then shifted left BITS; result truncated to DATA_SIZE bits, no saturation.
REQ-022 i_out_din/q_out_din SHALL be driven from registers holding the last assembled pair; they SHALL be stable for the whole S_WRITE residence.
REQ-023 In S_WRITE, i_out_wr_en and q_out_wr_en SHALL both be 1 exactly when i_out_full=0 AND q_out_full=0, and both 0 otherwise; the two SHALL never differ.
REQ-024 Write cycle SHALL transition S_WRITE -> S_READ next cycle; either FIFO full SHALL hold S_WRITE indefinitely.
REQ-025 Latency: pop of Q_hi in cycle N SHALL yield wr_en in cycle N+1 when outputs not full; steady-state throughput one pair per 5 cycles.
REQ-026 Output writes SHALL occur only in S_WRITE; wr_en SHALL be 0 in S_READ.

Reset
REQ-027 While reset=0: state S_READ, counter 0, byte slots 0, i_out_din=q_out_din=0, i_out_wr_en=q_out_wr_en=0, in_rd_en=0.
REQ-028 Reset asserted mid-record or in S_WRITE SHALL discard partial bytes and pending pair without writing; after release, next byte popped SHALL be treated as I_lo.
REQ-029 First pop SHALL be possible in the first rising edge after reset release with in_empty=0.

Verification
REQ-030 Bytes 01 00 FF FF, outputs not full -> one write: i_out_din=0x00000400, q_out_din=0xFFFFFC00.
REQ-031 Bytes FF 7F 00 80 -> i_out_din=0x01FFFC00, q_out_din=0xFE000000.
REQ-032 in_empty toggled 1/0 every cycle across a record -> in_rd_en mirrors NOT in_empty, exactly 4 pops, one correct write.
REQ-033 q_out_full=1 for 10 cycles at S_WRITE entry -> no wr_en, no pops, din stable; write occurs the cycle after q_out_full falls.
REQ-034 Reset pulse after 2 bytes of 01 00 02 00 ..., then stream 03 00 04 00 -> single write I=0x00000C00, Q=0x00001000; no write of pre-reset data.
REQ-035 1000 random records, random empty/full -> I and Q output sequences match golden model (sign-extend, shift by 10) bit-exactly, equal counts.
